hwpe_stream_tcdm_load_requester: RTL and testbench

- Upstream/downstream neighbour of the side-channel TCDM load FIFO stage.
- Issues a strided burst of TCDM read requests into the FIFO's slave port and tags each request with a side-channel "last" bit.
- Consumes the returned read data and re-emits it as a 32-bit HWPE stream with a last flag.
- Tracks outstanding requests and checks that the returned tags match.

---
 rtl/hwpe_stream_tcdm_load_requester.sv | 145 ++++++++++++++
 tb/tb_hwpe_stream_tcdm_load_requester.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_tcdm_load_requester.sv
// Strided TCDM load requester: issues a burst of tagged read requests into the
// side-channel load FIFO, re-emits the returned data as a 32-bit stream with a
// last flag, tracks outstanding requests and flags returned-tag mismatches.
module hwpe_stream_tcdm_load_requester #(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [CNT_WIDTH-1:0] n_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 tcdm_req_o,
  input  logic                 tcdm_gnt_i,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_data_o,
  output logic                 sidech_o,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  input  logic                 sidech_i,
  output logic                 tcdm_ready_o,
  output logic [31:0]          stream_data_o,
  output logic                 stream_valid_o,
  input  logic                 stream_ready_i,
  output logic                 stream_last_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [CNT_WIDTH-1:0] MaxOut = CNT_WIDTH'(MAX_OUTSTANDING);

  state_e               state_q;
  logic [31:0]          addr_q;
  logic [31:0]          stride_q;
  logic [CNT_WIDTH-1:0] n_q;
  logic [CNT_WIDTH-1:0] req_cnt_q;
  logic [CNT_WIDTH-1:0] resp_cnt_q;
  logic [CNT_WIDTH-1:0] outst_q;
  logic                 err_q;

  logic                 active;
  logic                 req;
  logic                 grant;
  logic                 hs;
  logic [CNT_WIDTH-1:0] n_last;
  logic                 last_req;
  logic                 last_resp;
  logic [CNT_WIDTH-1:0] outst_d;

  assign active    = (state_q != StIdle);
  // Stall issuing once the FIFO could not absorb another response.
  assign req       = (state_q == StReq) && (outst_q < MaxOut);
  assign grant     = req && tcdm_gnt_i;
  assign hs        = active && tcdm_r_valid_i && stream_ready_i;
  // With n_q == 0 this wraps to all-ones and never matches a live counter.
  assign n_last    = n_q - CNT_WIDTH'(1);
  assign last_req  = (req_cnt_q == n_last);
  assign last_resp = (resp_cnt_q == n_last);
  assign outst_d   = outst_q + CNT_WIDTH'(grant) - CNT_WIDTH'(hs);

  // Request side: address held in addr_q until granted.
  assign tcdm_req_o  = req;
  assign tcdm_add_o  = addr_q;
  assign tcdm_wen_o  = 1'b1;
  assign tcdm_be_o   = 4'hF;
  assign tcdm_data_o = 32'h0;
  assign sidech_o    = (state_q == StReq) && last_req;

  // Response side: zero-latency pass-through, silenced while idle.
  assign stream_valid_o = active && tcdm_r_valid_i;
  assign stream_data_o  = active ? tcdm_r_data_i : 32'h0;
  assign tcdm_ready_o   = active && stream_ready_i;
  assign stream_last_o  = active && last_resp;

  assign busy_o = active;
  assign done_o = (state_q == StDone);
  assign err_o  = err_q;

  // Control FSM with counters, address generator and sticky tag-error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= StIdle;
      addr_q     <= 32'h0;
      stride_q   <= 32'h0;
      n_q        <= '0;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      outst_q <= outst_d;
      if (grant) begin
        addr_q    <= addr_q + stride_q;
        req_cnt_q <= req_cnt_q + CNT_WIDTH'(1);
      end
      if (hs) begin
        resp_cnt_q <= resp_cnt_q + CNT_WIDTH'(1);
        if (sidech_i != stream_last_o) begin
          err_q <= 1'b1;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
            n_q        <= n_words_i;
            if (n_words_i != '0) begin
              addr_q   <= base_addr_i;
              stride_q <= stride_i;
              state_q  <= StReq;
            end else begin
              state_q  <= StDone;
            end
          end
        end
        StReq: begin
          if (grant && last_req) begin
            // Last grant and last response can coincide.
            state_q <= (hs && last_resp) ? StDone : StWait;
          end
        end
        StWait: begin
          if (hs && last_resp) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_requester.sv
// Bench for the strided TCDM load requester: cycle table for the basic burst,
// then a FIFO/TCDM model driving backpressure, wrap, tag-error/clear and
// random grant/ready bursts.
module tb_hwpe_stream_tcdm_load_requester;

  localparam int MaxOut = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [31:0] stride_i;
  logic [15:0] n_words_i;
  logic        busy_o, done_o, err_o;
  logic        tcdm_req_o, tcdm_gnt_i;
  logic [31:0] tcdm_add_o;
  logic        tcdm_wen_o;
  logic [3:0]  tcdm_be_o;
  logic [31:0] tcdm_data_o;
  logic        sidech_o;
  logic [31:0] tcdm_r_data_i;
  logic        tcdm_r_valid_i, sidech_i, tcdm_ready_o;
  logic [31:0] stream_data_o;
  logic        stream_valid_o, stream_ready_i, stream_last_o;

  hwpe_stream_tcdm_load_requester #(
    .MAX_OUTSTANDING(MaxOut),
    .CNT_WIDTH      (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .stride_i      (stride_i),
    .n_words_i     (n_words_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .tcdm_req_o    (tcdm_req_o),
    .tcdm_gnt_i    (tcdm_gnt_i),
    .tcdm_add_o    (tcdm_add_o),
    .tcdm_wen_o    (tcdm_wen_o),
    .tcdm_be_o     (tcdm_be_o),
    .tcdm_data_o   (tcdm_data_o),
    .sidech_o      (sidech_o),
    .tcdm_r_data_i (tcdm_r_data_i),
    .tcdm_r_valid_i(tcdm_r_valid_i),
    .sidech_i      (sidech_i),
    .tcdm_ready_o  (tcdm_ready_o),
    .stream_data_o (stream_data_o),
    .stream_valid_o(stream_valid_o),
    .stream_ready_i(stream_ready_i),
    .stream_last_o (stream_last_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  function automatic logic [71:0] pk(input logic req, input logic [31:0] add, input logic sc,
                                     input logic v, input logic [31:0] d, input logic last,
                                     input logic done, input logic busy, input logic err,
                                     input logic rdy);
    return {req, add, sc, v, d, last, done, busy, err, rdy};
  endfunction

  function automatic logic [71:0] outs();
    return pk(tcdm_req_o, tcdm_add_o, sidech_o, stream_valid_o, stream_data_o, stream_last_o,
              done_o, busy_o, err_o, tcdm_ready_o);
  endfunction

  typedef struct {
    logic        start;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        rs;
    logic        rdy;
    logic [71:0] exp;
  } vec_t;

  vec_t vecs[8];

  // FIFO/TCDM model state
  typedef struct {
    logic [31:0] data;
    logic        tag;
  } resp_t;

  resp_t       q[$];
  logic [31:0] addr_log[$];
  int          gi, ri, n_cur, flip_idx, done_cnt, gcyc, last_hs_cyc;
  logic [31:0] exp_addr, stride_cur;
  bit          err_exp;

  task automatic model_cycle(input bit gnt, input bit rdy);
    bit    hs, pop, mm;
    resp_t r;
    mm = 1'b0;
    tcdm_gnt_i     = gnt;
    stream_ready_i = rdy;
    if (q.size() != 0) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = q[0].data;
      sidech_i       = q[0].tag ^ (ri == flip_idx);
    end else begin
      tcdm_r_valid_i = 1'b0;
      tcdm_r_data_i  = 32'hDEAD_BEEF;
      sidech_i       = 1'b0;
    end
    #2;
    chk("err", 72'(err_o), 72'(err_exp));
    if (q.size() >= MaxOut) chk("outst_cap", 72'(tcdm_req_o), 72'(0));
    if (done_o) begin
      done_cnt++;
      chk("done_lat", 72'(gcyc), 72'(last_hs_cyc + 1));
    end
    hs  = stream_valid_o && stream_ready_i;
    pop = tcdm_r_valid_i && tcdm_ready_o;
    if (hs || pop) chk("pop_vs_hs", 72'(pop), 72'(hs));
    if (hs) begin
      chk("rdata", 72'(stream_data_o), 72'(32'hC0DE_0000 + 32'(ri)));
      chk("rlast", 72'(stream_last_o), 72'(ri == n_cur - 1));
      mm = (sidech_i != (ri == n_cur - 1));
      ri++;
      last_hs_cyc = gcyc;
    end
    if (pop) void'(q.pop_front());
    if (tcdm_req_o && gnt) begin
      chk("req_add", 72'(tcdm_add_o), 72'(exp_addr));
      chk("req_tag", 72'(sidech_o), 72'(gi == n_cur - 1));
      chk("gnt_overrun", 72'(gi < n_cur), 72'(1));
      r.data = 32'hC0DE_0000 + 32'(gi);
      r.tag  = sidech_o;
      q.push_back(r);
      addr_log.push_back(tcdm_add_o);
      gi++;
      exp_addr = exp_addr + stride_cur;
    end
    if (mm) err_exp = 1'b1;
    gcyc++;
    @(negedge clk_i);
  endtask

  task automatic begin_burst(input logic [31:0] base, input logic [31:0] stride, input int n,
                             input int flip);
    base_addr_i = base;
    stride_i    = stride;
    n_words_i   = 16'(n);
    n_cur       = n;
    flip_idx    = flip;
    gi          = 0;
    ri          = 0;
    done_cnt    = 0;
    last_hs_cyc = -10;
    exp_addr    = base;
    stride_cur  = stride;
    addr_log.delete();
    start_i = 1'b1;
    model_cycle(1'b0, 1'b1);
    start_i = 1'b0;
  endtask

  task automatic run_burst(input logic [31:0] base, input logic [31:0] stride, input int n,
                           input bit rnd, input int hold);
    int cyc;
    bit g, r;
    begin_burst(base, stride, n, -1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      g = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      r = (cyc < hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      model_cycle(g, r);
      if (hold > 0 && cyc == hold - 1) begin
        chk("bp_grants", 72'(gi), 72'(MaxOut));
        chk("bp_req", 72'(tcdm_req_o), 72'(0));
        chk("bp_add", 72'(tcdm_add_o), 72'(base + 32'(MaxOut) * stride));
      end
      cyc++;
    end
    chk("done_seen", 72'(done_cnt), 72'(1));
    repeat (2) model_cycle(1'b1, 1'b1);
    chk("done_once", 72'(done_cnt), 72'(1));
    chk("n_grants", 72'(gi), 72'(n));
    chk("n_resps", 72'(ri), 72'(n));
    chk("idle_after", 72'(busy_o), 72'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with junk on every input: outputs must stay quiet.
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b1; tcdm_gnt_i = 1'b1;
    base_addr_i = 32'h1000; stride_i = 32'h4; n_words_i = 16'd4;
    tcdm_r_valid_i = 1'b1; tcdm_r_data_i = 32'hFFFF_FFFF; sidech_i = 1'b1;
    stream_ready_i = 1'b1;
    q.delete(); err_exp = 1'b0; gcyc = 0; last_hs_cyc = -10;
    repeat (3) @(negedge clk_i);
    #2;
    chk("rst_outs", outs(), 72'(0));
    chk("rst_wen_be", 72'({tcdm_wen_o, tcdm_be_o}), 72'(5'h1F));
    chk("rst_wdata", 72'(tcdm_data_o), 72'(0));
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0; tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0;
    tcdm_r_data_i = 32'h0; sidech_i = 1'b0;

    // Basic burst base=0x1000 stride=4 n=4, always grant, ready=1; starts in
    // REQ and DONE are ignored.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
                pk(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0)};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1,
                pk(1, 32'h1000, 0, 0, 32'h0, 0, 0, 1, 0, 1)};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'hA000_0000, 1'b0, 1'b1,
                pk(1, 32'h1004, 0, 1, 32'hA000_0000, 0, 0, 1, 0, 1)};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'hA000_0001, 1'b0, 1'b1,
                pk(1, 32'h1008, 0, 1, 32'hA000_0001, 0, 0, 1, 0, 1)};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'hA000_0002, 1'b0, 1'b1,
                pk(1, 32'h100C, 1, 1, 32'hA000_0002, 0, 0, 1, 0, 1)};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'hA000_0003, 1'b1, 1'b1,
                pk(0, 32'h1010, 0, 1, 32'hA000_0003, 1, 0, 1, 0, 1)};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
                pk(0, 32'h1010, 0, 0, 32'h0, 0, 1, 1, 0, 1)};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
                pk(0, 32'h1010, 0, 0, 32'h0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 8; i++) begin
      start_i        = vecs[i].start;
      tcdm_gnt_i     = vecs[i].gnt;
      tcdm_r_valid_i = vecs[i].rv;
      tcdm_r_data_i  = vecs[i].rd;
      sidech_i       = vecs[i].rs;
      stream_ready_i = vecs[i].rdy;
      #2;
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      @(negedge clk_i);
    end
    start_i = 1'b0; tcdm_gnt_i = 1'b0;

    // Zero-length burst: straight to DONE, no requests.
    n_words_i = 16'd0; start_i = 1'b1;
    #2;
    chk("z0_req", 72'(tcdm_req_o), 72'(0));
    chk("z0_busy", 72'(busy_o), 72'(0));
    @(negedge clk_i);
    start_i = 1'b0;
    #2;
    chk("z1_req", 72'(tcdm_req_o), 72'(0));
    chk("z1_busy", 72'(busy_o), 72'(1));
    chk("z1_done", 72'(done_o), 72'(1));
    @(negedge clk_i);
    #2;
    chk("z2_req", 72'(tcdm_req_o), 72'(0));
    chk("z2_busy", 72'(busy_o), 72'(0));
    chk("z2_done", 72'(done_o), 72'(0));
    @(negedge clk_i);

    // Backpressure: consumer stalled 30 cycles, outstanding capped at 8.
    run_burst(32'h3000, 32'h4, 20, 1'b0, 30);

    // Negative stride with address wrap.
    run_burst(32'h4, 32'hFFFF_FFFC, 3, 1'b0, 0);
    chk("wrap_n", 72'(addr_log.size()), 72'(3));
    if (addr_log.size() == 3) begin
      chk("wrap_a0", 72'(addr_log[0]), 72'(32'h4));
      chk("wrap_a1", 72'(addr_log[1]), 72'(32'h0));
      chk("wrap_a2", 72'(addr_log[2]), 72'(32'hFFFF_FFFC));
    end

    // Tag error on word 1 of 4, then clear mid-burst.
    begin_burst(32'h2000, 32'h4, 4, 1);
    repeat (4) model_cycle(1'b1, 1'b1);
    chk("err_rise", 72'(err_o), 72'(1));
    chk("mid_busy", 72'(busy_o), 72'(1));
    tcdm_gnt_i = 1'b0;
    clear_i    = 1'b1;
    #2;
    chk("err_hold", 72'(err_o), 72'(1));
    @(negedge clk_i);
    clear_i = 1'b0;
    q.delete();
    err_exp = 1'b0;
    tcdm_r_valid_i = 1'b0;
    #2;
    chk("clr_busy", 72'(busy_o), 72'(0));
    chk("clr_err", 72'(err_o), 72'(0));
    chk("clr_req", 72'(tcdm_req_o), 72'(0));
    chk("clr_valid", 72'(stream_valid_o), 72'(0));
    @(negedge clk_i);

    // Random grant and ready.
    run_burst(32'h8000, 32'h8, 100, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
